// File: rtl/uart_byte_tx.sv
// -----------------------------------------------------------------------------
// uart_byte_tx
//
// Purpose:
//   8N1 serial transmitter for one byte per request. It sits downstream of the
//   32-bit-to-byte sequencer in Key_Cnt. A frame is a start bit (0), eight data
//   bits LSB first, and a stop bit (1). Every bit lasts D clock cycles, where D
//   is taken from a small baud table when the request is accepted. Tx_Done
//   pulses for one cycle at the end of the frame so the sequencer can move on
//   to the next byte.
//
// Ports:
//   Clk        in   system clock
//   Rst_n      in   asynchronous active-low reset
//   Send_en    in   start request, one-cycle pulse, sampled only while idle
//   data_byte  in   [7:0] byte to send, captured together with an accepted Send_en
//   baud_set   in   [2:0] 0=9600 1=19200 2=38400 3=57600 4=115200 5..7=9600
//   Rs232_Tx   out  serial line, registered, idles high
//   Tx_Done    out  one-cycle pulse at the end of a frame
//   uart_state out  busy flag, high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_byte_tx #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Send_en,
    input  logic [7:0] data_byte,
    input  logic [2:0] baud_set,
    output logic       Rs232_Tx,
    output logic       Tx_Done,
    output logic       uart_state
);

    localparam logic IDLE = 1'b0;
    localparam logic SEND = 1'b1;

    // Bit periods in clock cycles. Integer division truncates.
    localparam logic [12:0] DIV_9600   = 13'(CLK_FREQ / 9600);
    localparam logic [12:0] DIV_19200  = 13'(CLK_FREQ / 19200);
    localparam logic [12:0] DIV_38400  = 13'(CLK_FREQ / 38400);
    localparam logic [12:0] DIV_57600  = 13'(CLK_FREQ / 57600);
    localparam logic [12:0] DIV_115200 = 13'(CLK_FREQ / 115200);

    logic        r_state;
    logic        r_tx;
    logic        r_done;
    logic [7:0]  r_data;
    logic [12:0] r_div;
    logic [12:0] r_div_cnt;
    logic [3:0]  r_bit_idx;
    logic [12:0] w_div_sel;
    logic        w_bit_end;

    always_comb begin
        w_div_sel = DIV_9600;
        case (baud_set)
            3'd1:    w_div_sel = DIV_19200;
            3'd2:    w_div_sel = DIV_38400;
            3'd3:    w_div_sel = DIV_57600;
            3'd4:    w_div_sel = DIV_115200;
            default: w_div_sel = DIV_9600;
        endcase
    end

    // This is the last cycle of the current bit period.
    assign w_bit_end = (r_div_cnt == r_div - 13'd1);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state   <= IDLE;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
            r_data    <= 8'd0;
            r_div     <= 13'd0;
            r_div_cnt <= 13'd0;
            r_bit_idx <= 4'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (Send_en) begin
                        // Capture the data and the divider now. Later changes
                        // to the inputs do not affect this frame.
                        r_data    <= data_byte;
                        r_div     <= w_div_sel;
                        r_state   <= SEND;
                        r_tx      <= 1'b0;
                        r_div_cnt <= 13'd0;
                        r_bit_idx <= 4'd0;
                    end
                end
                SEND: begin
                    if (r_bit_idx > 4'd9) begin
                        // The index cannot be valid here. Return to idle.
                        r_state   <= IDLE;
                        r_tx      <= 1'b1;
                        r_div_cnt <= 13'd0;
                        r_bit_idx <= 4'd0;
                    end else if (w_bit_end) begin
                        r_div_cnt <= 13'd0;
                        if (r_bit_idx == 4'd9) begin
                            // The stop bit has run for its full period.
                            r_state   <= IDLE;
                            r_done    <= 1'b1;
                            r_tx      <= 1'b1;
                            r_bit_idx <= 4'd0;
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                            // Leaving bit b drives bit b+1. For b = 0..7 that
                            // is data[b]. Leaving data bit 7 drives the stop bit.
                            if (r_bit_idx == 4'd8)
                                r_tx <= 1'b1;
                            else
                                r_tx <= r_data[r_bit_idx[2:0]];
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 13'd1;
                    end
                end
            endcase
        end
    end

    assign Rs232_Tx   = r_tx;
    assign Tx_Done    = r_done;
    assign uart_state = r_state;

endmodule

// File: tb/tb_uart_byte_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_byte_tx
//
// Scoreboard bench for uart_byte_tx. The stimulus side pushes the expected
// frame (byte, bit period, idle gap before it) whenever it issues a request
// the DUT should accept. The monitor pops an entry at each frame start and
// checks every bit period sample by sample, then checks the Tx_Done pulse.
// -----------------------------------------------------------------------------
module tb_uart_byte_tx;

    logic       Clk;
    logic       Rst_n;
    logic       Send_en;
    logic [7:0] data_byte;
    logic [2:0] baud_set;
    logic       Rs232_Tx;
    logic       Tx_Done;
    logic       uart_state;

    uart_byte_tx #(.CLK_FREQ(50_000_000)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Send_en    (Send_en),
        .data_byte  (data_byte),
        .baud_set   (baud_set),
        .Rs232_Tx   (Rs232_Tx),
        .Tx_Done    (Tx_Done),
        .uart_state (uart_state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] data;
        int         div;
        int         gap;   // expected done-to-start distance; -1 = don't care
    } exp_t;

    exp_t sb_q[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   done_cyc  = 0;
    int   done_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_div(input logic [2:0] b);
        case (b)
            3'd1:    return 2604;
            3'd2:    return 1302;
            3'd3:    return 868;
            3'd4:    return 434;
            default: return 5208;
        endcase
    endfunction

    always @(posedge Clk) cyc <= cyc + 1;
    always @(negedge Clk) if (Tx_Done === 1'b1) done_cnt <= done_cnt + 1;

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t     e;
        bit [9:0] bits;
        int       good;
        bit       abort;
        forever begin
            @(negedge Clk);
            if (Rst_n && uart_state === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                    while (Rst_n && uart_state === 1'b1) @(negedge Clk);
                end else begin
                    e = sb_q.pop_front();
                    if (e.gap >= 0) check("gap", cyc - done_cyc, e.gap);
                    bits  = {1'b1, e.data, 1'b0};
                    abort = 1'b0;
                    for (int k = 0; k < 10 && !abort; k++) begin
                        good = 0;
                        for (int c = 0; c < e.div; c++) begin
                            if (c > 0 || k > 0) @(negedge Clk);
                            if (!Rst_n) begin
                                abort = 1'b1;
                                break;
                            end
                            if (Rs232_Tx === bits[k] && uart_state === 1'b1 && Tx_Done === 1'b0)
                                good++;
                        end
                        if (!abort) check($sformatf("byte%02h_bit%0d", e.data, k), good, e.div);
                    end
                    if (!abort) begin
                        @(negedge Clk);
                        check($sformatf("byte%02h_done_hi", e.data),
                              {29'd0, Tx_Done, uart_state, Rs232_Tx}, 32'b101);
                        done_cyc = cyc;
                        @(negedge Clk);
                        check($sformatf("byte%02h_done_lo", e.data), {31'd0, Tx_Done}, 0);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_send(input logic [7:0] d, input logic [2:0] b);
        @(posedge Clk); #1;
        Send_en   = 1'b1;
        data_byte = d;
        baud_set  = b;
        @(posedge Clk); #1;
        Send_en   = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic [2:0] b);
        exp_t e;
        e.data = d; e.div = exp_div(b); e.gap = -1;
        sb_q.push_back(e);
        pulse_send(d, b);
        $display("[TB] send byte=%02h baud_set=%0d div=%0d", d, b, e.div);
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (Tx_Done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({"timeout_", tag}, 0, 1);
    endtask

    task automatic pulse_reset(input int hold);
        #3 Rst_n = 1'b0;
        repeat (hold) @(posedge Clk);
        #1 Rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int   snap;
        exp_t e;
        logic [7:0] b2b [3];
        b2b[0] = 8'h34; b2b[1] = 8'h56; b2b[2] = 8'h78;

        Rst_n = 1'b0; Send_en = 1'b0; data_byte = 8'h00; baud_set = 3'd4;

        // Reset held with Send_en toggling.
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1;
            Send_en   = ~Send_en;
            data_byte = 8'h5A;
            @(negedge Clk);
            check("rst_tx",   {31'd0, Rs232_Tx},   1);
            check("rst_done", {31'd0, Tx_Done},    0);
            check("rst_busy", {31'd0, uart_state}, 0);
        end
        Send_en = 1'b0;
        @(posedge Clk); #1 Rst_n = 1'b1;
        repeat (3) @(posedge Clk);

        // Single frame.
        send(8'hA5, 3'd4);
        wait_done("single", 6000);
        @(posedge Clk); #1;
        check("single_done_cnt", done_cnt, 1);

        // Busy rejection: second request lands in data bit 3.
        send(8'hA5, 3'd4);
        repeat (4 * 434 + 200) @(posedge Clk);
        pulse_send(8'hFF, 3'd4);
        $display("[TB] busy request byte=ff (should be dropped)");
        wait_done("busy", 6000);
        repeat (600) @(posedge Clk); #1;
        check("busy_done_cnt", done_cnt, 2);
        check("busy_idle", {31'd0, uart_state}, 0);

        // Back-to-back with the sequencer handshake.
        send(8'h12, 3'd4);
        for (int i = 0; i < 3; i++) begin
            wait_done("b2b", 6000);
            @(posedge Clk); #1;
            e.data = b2b[i]; e.div = 434; e.gap = 2;
            sb_q.push_back(e);
            Send_en = 1'b1; data_byte = b2b[i]; baud_set = 3'd4;
            @(posedge Clk); #1;
            Send_en = 1'b0;
            $display("[TB] send byte=%02h baud_set=4 div=434 (handshake)", b2b[i]);
        end
        wait_done("b2b_last", 6000);
        @(posedge Clk); #1;
        check("b2b_done_cnt", done_cnt, 6);

        // Reset during data bit 3.
        send(8'h96, 3'd4);
        repeat (4 * 434 + 100) @(posedge Clk);
        snap = done_cnt;
        #3 Rst_n = 1'b0;
        #1;
        check("midrst_tx",   {31'd0, Rs232_Tx},   1);
        check("midrst_busy", {31'd0, uart_state}, 0);
        repeat (3) @(posedge Clk);
        #1 Rst_n = 1'b1;
        repeat (20) @(posedge Clk); #1;
        check("midrst_no_done", done_cnt, snap);
        check("midrst_idle", {31'd0, uart_state}, 0);
        send(8'h3C, 3'd4);
        wait_done("after_rst", 6000);
        @(posedge Clk); #1;
        check("after_rst_done_cnt", done_cnt, snap + 1);

        // baud_set changed mid-frame has no effect.
        send(8'hC3, 3'd4);
        @(posedge Clk); #1 baud_set = 3'd0;
        wait_done("baud_latch", 6000);
        @(posedge Clk); #1;
        check("baud_latch_done_cnt", done_cnt, snap + 2);

        // baud_set 0 and 7: check the first two bit periods, then abort.
        send(8'h01, 3'd0);
        repeat (2 * 5208 + 50) @(posedge Clk);
        pulse_reset(2);
        repeat (5) @(posedge Clk);
        send(8'h01, 3'd7);
        repeat (2 * 5208 + 50) @(posedge Clk);
        pulse_reset(2);
        repeat (10) @(posedge Clk); #1;
        check("sb_empty", sb_q.size(), 0);
        check("final_idle", {31'd0, uart_state}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
